// File: rtl/timing_sequencer.sv
// Computer-cycle timing generator: W/X/Y/Z sub-bit strobes, bit-time and
// phase counts, one-hot bit decodes, plus run/halt and single-step control.
module timing_sequencer #(
    parameter int BITS_PER_PHASE = 14,
    parameter int PHASES         = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      step_req,
    output logic                      step_ack,
    output logic                      clk_w,
    output logic                      clk_x,
    output logic                      clk_y,
    output logic                      clk_z,
    output logic [3:0]                bit_time,
    output logic [BITS_PER_PHASE-1:0] bit_strobe,
    output logic [1:0]                phase,
    output logic                      cycle_end,
    output logic                      halted
);

    localparam logic [3:0] BT_LAST = 4'(BITS_PER_PHASE - 1);
    localparam logic [1:0] PH_LAST = 2'(PHASES - 1);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] sub;
    logic       active;

    assign active    = (state != HALT);
    assign halted    = (state == HALT);
    assign clk_w     = active && (sub == 2'd0);
    assign clk_x     = active && (sub == 2'd1);
    assign clk_y     = active && (sub == 2'd2);
    assign clk_z     = active && (sub == 2'd3);
    assign cycle_end = active && (phase == PH_LAST)
                       && (bit_time == BT_LAST) && (sub == 2'd3);

    always_comb begin
        bit_strobe = '0;
        for (int i = 0; i < BITS_PER_PHASE; i++) begin
            bit_strobe[i] = active && (bit_time == 4'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HALT;
            sub      <= 2'd0;
            bit_time <= 4'd0;
            phase    <= 2'd0;
            step_ack <= 1'b0;
        end else begin
            step_ack <= 1'b0;
            // Counters wrap to zero exactly at cycle_end, so HALT is
            // always entered aligned to phase 0, bit 0, W.
            if (active) begin
                sub <= sub + 2'd1;
                if (sub == 2'd3) begin
                    if (bit_time == BT_LAST) begin
                        bit_time <= 4'd0;
                        phase    <= (phase == PH_LAST) ? 2'd0 : phase + 2'd1;
                    end else begin
                        bit_time <= bit_time + 4'd1;
                    end
                end
            end
            unique case (state)
                HALT: begin
                    if (run) begin
                        state <= RUN;
                    end else if (step_req) begin
                        state <= STEP;
                    end
                end
                RUN: begin
                    if (cycle_end && !run) begin
                        state <= HALT;
                    end
                end
                STEP: begin
                    if (cycle_end) begin
                        state    <= HALT;
                        step_ack <= 1'b1;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

endmodule
